// File: rtl/alu_seq_flags.sv
// Sequential WIDTH-bit ALU with registered result/flags, a start/busy/done handshake
// and an optional iterative shift-add multiplier on op 4'h7.
module alu_seq_flags #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             use_cin,
    output logic [WIDTH-1:0] result,
    output logic             negativo,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q;
    logic               neg_q, zero_q, cout_q, ovf_q, done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;

    logic               is_mul, single_go, mul_go, mul_step, mul_last;
    logic [WIDTH-1:0]   opb, alu_res;
    logic [WIDTH:0]     sum;
    logic               cin, alu_cout, alu_ovf, alu_upd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_go)   state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; a start while multiplying is simply never accepted
    always_comb begin
        is_mul    = MUL_EN && (op == 4'h7);
        single_go = (state_q == S_IDLE) && start && !is_mul;
        mul_go    = (state_q == S_IDLE) && start && is_mul;
        mul_step  = (state_q == S_MUL);
        mul_last  = (state_q == S_MUL) && (cnt_q == LAST);
        busy      = (state_q == S_MUL);
    end

    // Single-cycle datapath: one WIDTH+1 adder shared by ADD/SUB/INC/DEC
    always_comb begin
        opb      = B;
        cin      = 1'b0;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_upd  = 1'b1;
        case (op)
            4'h0: begin opb = B;          cin = use_cin ? cout_q : 1'b0; end
            4'h1: begin opb = ~B;         cin = use_cin ? cout_q : 1'b1; end
            4'h2: begin opb = WIDTH'(1);  cin = 1'b0; end
            4'h3: begin opb = '1;         cin = 1'b0; end
            default: opb = B;
        endcase
        sum = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (A[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'h4:    alu_res = A & B;
            4'h5:    alu_res = A | B;
            4'h6:    alu_res = A ^ B;
            default: alu_upd = 1'b0;
        endcase
    end

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Multiplier operand/accumulator registers (pure data, no reset needed)
    always_ff @(posedge clk) begin
        if (mul_go) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, A};
            mplier_q <= B;
        end else if (mul_step) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Result, flags, done pulse and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= single_go || mul_last;
            if (mul_go)
                cnt_q <= '0;
            else if (mul_step)
                cnt_q <= cnt_q + 1'b1;
            if (single_go && alu_upd) begin
                result_q <= alu_res;
                neg_q    <= alu_res[WIDTH-1];
                zero_q   <= (alu_res == '0);
                cout_q   <= alu_cout;
                ovf_q    <= alu_ovf;
            end else if (mul_last) begin
                result_q <= acc_d[WIDTH-1:0];
                neg_q    <= acc_d[WIDTH-1];
                zero_q   <= (acc_d[WIDTH-1:0] == '0);
                cout_q   <= |acc_d[2*WIDTH-1:WIDTH];
                ovf_q    <= 1'b0;
            end
        end
    end

    assign result   = result_q;
    assign negativo = neg_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Randomized and directed bench for alu_seq_flags (WIDTH=8, MUL_EN=1) against an
// integer-arithmetic reference model.
module tb_alu_seq_flags;

    logic       clk = 1'b0;
    logic       rst, start, use_cin;
    logic [3:0] op;
    logic [7:0] A, B;
    logic [7:0] result;
    logic       negativo, zero, cout, overflow, busy, done;

    int checks = 0;
    int errors = 0;

    int m_res;
    bit m_n, m_z, m_c, m_v;

    alu_seq_flags #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .use_cin(use_cin),
        .result(result), .negativo(negativo), .zero(zero), .cout(cout),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_result"},   32'(result),   32'(m_res));
        chk({tag, "_negativo"}, 32'(negativo), 32'(m_n));
        chk({tag, "_zero"},     32'(zero),     32'(m_z));
        chk({tag, "_cout"},     32'(cout),     32'(m_c));
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_v));
    endtask

    task automatic model_reset();
        m_res = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    endtask

    // Plain-integer view of the operation rules
    task automatic model_apply(input int o, input int a, input int b, input bit uc);
        int c, ob, s, sa, sob, ss, p, res;
        bit nc, nv;
        bit upd = 1;
        c = 0; ob = b; res = 0; nc = 0; nv = 0;
        case (o)
            0: begin ob = b;       c = uc ? int'(m_c) : 0; end
            1: begin ob = 255 - b; c = uc ? int'(m_c) : 1; end
            2: begin ob = 1;       c = 0; end
            3: begin ob = 255;     c = 0; end
            default: ;
        endcase
        if (o <= 3) begin
            s   = a + ob + c;
            sa  = (a >= 128) ? a - 256 : a;
            sob = (ob >= 128) ? ob - 256 : ob;
            ss  = sa + sob + c;
            res = s % 256;
            nc  = (s > 255);
            nv  = (ss > 127) || (ss < -128);
        end else if (o == 4) res = a & b;
        else if (o == 5) res = a | b;
        else if (o == 6) res = a ^ b;
        else if (o == 7) begin
            p   = a * b;
            res = p % 256;
            nc  = (p > 255);
        end else upd = 0;
        if (upd) begin
            m_res = res;
            m_n   = (res >= 128);
            m_z   = (res == 0);
            m_c   = nc;
            m_v   = nv;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input bit uc, input bit poke);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; use_cin = uc;
        model_apply(int'(o), int'(a), int'(b), uc);
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 4'h7) begin
            chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
            chk({tag, "_done_e0"}, 32'(done), 32'd0);
            for (int i = 1; i < 8; i++) begin
                if (poke && i == 3) begin
                    start = 1'b1; op = 4'h0; A = 8'h01; B = 8'h01;
                end
                @(posedge clk); #1;
                start = 1'b0;
                chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
                chk({tag, "_done_mid"}, 32'(done), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        check_outs(tag);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        check_outs({tag, "_hold"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'h0; A = 8'h00; B = 8'h00; use_cin = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_outs("rst");
        rst = 1'b0;

        run_op("add_7f_01", 4'h0, 8'h7F, 8'h01, 1'b0, 1'b0);
        chk("add_7f_01_val", 32'(result), 32'h80);
        run_op("sub_05_05", 4'h1, 8'h05, 8'h05, 1'b0, 1'b0);
        chk("sub_05_05_zero", 32'(zero), 32'd1);
        run_op("sub_00_01", 4'h1, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("sub_00_01_val", 32'(result), 32'hFF);
        run_op("inc_ff", 4'h2, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("inc_ff_cout", 32'(cout), 32'd1);
        run_op("adc_10_20", 4'h0, 8'h10, 8'h20, 1'b1, 1'b0);
        chk("adc_10_20_val", 32'(result), 32'h31);
        run_op("dec_80", 4'h3, 8'h80, 8'h00, 1'b0, 1'b0);
        run_op("nop_f", 4'hF, 8'h12, 8'h34, 1'b0, 1'b0);
        run_op("mul_0f_11", 4'h7, 8'h0F, 8'h11, 1'b0, 1'b1);
        chk("mul_0f_11_val", 32'(result), 32'hFF);
        run_op("mul_10_10", 4'h7, 8'h10, 8'h10, 1'b0, 1'b0);
        chk("mul_10_10_cout", 32'(cout), 32'd1);

        // Reset during a multiply aborts it with no done
        @(negedge clk);
        start = 1'b1; op = 4'h7; A = 8'h33; B = 8'h44;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("mulrst_busy", 32'(busy), 32'd0);
        chk("mulrst_done", 32'(done), 32'd0);
        check_outs("mulrst");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mulrst_nodone", 32'(done), 32'd0);
        end
        run_op("add_01_01", 4'h0, 8'h01, 8'h01, 1'b0, 1'b0);
        chk("add_01_01_val", 32'(result), 32'h02);

        // Simultaneous reset and start drops the request
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 4'h7; A = 8'h05; B = 8'h07;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        model_reset();
        chk("rststart_busy", 32'(busy), 32'd0);
        chk("rststart_done", 32'(done), 32'd0);
        check_outs("rststart");

        for (int n = 0; n < 200; n++) begin
            run_op("rnd", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
